// File: rtl/mbist_pkg.sv
// Shared types and March C- element table for the MBIST controller.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned ELEM_W = 3;
    typedef logic [ELEM_W-1:0] elem_t;

    localparam elem_t M0 = 3'd0;
    localparam elem_t M1 = 3'd1;
    localparam elem_t M2 = 3'd2;
    localparam elem_t M3 = 3'd3;
    localparam elem_t M4 = 3'd4;
    localparam elem_t M5 = 3'd5;

    // Per-element attributes: address direction, read/write backgrounds, single-op kind
    typedef struct packed {
        logic down;
        logic rd_bg;
        logic wr_bg;
        logic rd_only;
        logic wr_only;
    } elem_cfg_t;

    // March C- element table
    function automatic elem_cfg_t elem_cfg(elem_t e);
        elem_cfg_t c;
        c = '0;
        case (e)
            M0:      c = '{down: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0, rd_only: 1'b0, wr_only: 1'b1};
            M1:      c = '{down: 1'b0, rd_bg: 1'b0, wr_bg: 1'b1, rd_only: 1'b0, wr_only: 1'b0};
            M2:      c = '{down: 1'b0, rd_bg: 1'b1, wr_bg: 1'b0, rd_only: 1'b0, wr_only: 1'b0};
            M3:      c = '{down: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1, rd_only: 1'b0, wr_only: 1'b0};
            M4:      c = '{down: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0, rd_only: 1'b0, wr_only: 1'b0};
            M5:      c = '{down: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0, rd_only: 1'b1, wr_only: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for March elements; load selects 0 (ascending) or N-1 (descending).
module mbist_addr_gen #(
    parameter int unsigned ADDR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            load_down,
    input  logic            step,
    input  logic            down,
    output logic [ADDR-1:0] addr,
    output logic            tc_c
);

    // Address register: load has priority over step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR'(1) : addr + ADDR'(1);
        end
    end

    // Terminal count for the current sweep direction
    assign tc_c = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: sole initiator of the memory under test.
// Optional build macro MBIST_STOP_ON_FAIL_EN ends the test at the first mismatch.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR = 4,
    parameter int unsigned DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            mem_wen,
    output logic            mem_ren,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_din,
    input  logic [DATA-1:0] mem_dout,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ADDR-1:0] fail_addr,
    output logic [2:0]      fail_elem,
    output logic [DATA-1:0] fail_data,
    output logic [7:0]      fail_count
);

    localparam int unsigned CNT_W = 8;

    state_t     state, state_nxt;
    elem_t      elem, elem_nxt;
    logic       phase, phase_nxt;
    elem_cfg_t  cur_cfg, nxt_cfg;

    logic       addr_load, addr_load_down, addr_step, addr_tc_c;
    logic       start_go_c, mismatch_c;

    logic            cmp_vld;
    logic [DATA-1:0] cmp_exp;
    logic [ADDR-1:0] cmp_addr;
    elem_t           cmp_elem;

    logic             op_wen, op_ren;
    logic [DATA-1:0]  op_din;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [CNT_W-1:0] fail_count_nxt;
    logic [ADDR-1:0]  fail_addr_nxt;
    elem_t            fail_elem_nxt;
    logic [DATA-1:0]  fail_data_nxt;

    assign cur_cfg    = elem_cfg(elem);
    assign nxt_cfg    = elem_cfg(elem_nxt);
    assign start_go_c = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch_c = cmp_vld && ((state == ST_RUN) || (state == ST_DRAIN))
                        && (mem_dout != cmp_exp);

    mbist_addr_gen #(.ADDR(ADDR)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (addr_load),
        .load_down (addr_load_down),
        .step      (addr_step),
        .down      (cur_cfg.down),
        .addr      (mem_addr),
        .tc_c      (addr_tc_c)
    );

    // FSM state register with element and R/W phase counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            elem  <= M0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            elem  <= elem_nxt;
            phase <= phase_nxt;
        end
    end

    // Next-state: walk phase, then address, then element
    always_comb begin
        state_nxt      = state;
        elem_nxt       = elem;
        phase_nxt      = phase;
        addr_load      = 1'b0;
        addr_load_down = 1'b0;
        addr_step      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt      = ST_RUN;
                    elem_nxt       = M0;
                    phase_nxt      = 1'b0;
                    addr_load      = 1'b1;
                    addr_load_down = elem_cfg(M0).down;
                end
            end
            ST_RUN: begin
                if (!cur_cfg.rd_only && !cur_cfg.wr_only && !phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (addr_tc_c) begin
                        if (elem == M5) begin
                            state_nxt = ST_DRAIN;
                        end else begin
                            elem_nxt       = elem + elem_t'(1);
                            addr_load      = 1'b1;
                            addr_load_down = elem_cfg(elem + elem_t'(1)).down;
                        end
                    end else begin
                        addr_step = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef MBIST_STOP_ON_FAIL_EN
        if (mismatch_c) begin
            state_nxt = ST_DONE;
            addr_load = 1'b0;
            addr_step = 1'b0;
        end
`endif
    end

    // Output decode: next memory op and result bookkeeping
    always_comb begin
        op_wen         = 1'b0;
        op_ren         = 1'b0;
        op_din         = '0;
        busy_nxt       = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
        done_nxt       = (state_nxt == ST_DONE);
        pass_nxt       = pass;
        fail_count_nxt = fail_count;
        fail_addr_nxt  = fail_addr;
        fail_elem_nxt  = fail_elem;
        fail_data_nxt  = fail_data;

        if (state_nxt == ST_RUN) begin
            if (nxt_cfg.wr_only || phase_nxt) begin
                op_wen = 1'b1;
                op_din = {DATA{nxt_cfg.wr_bg}};
            end else begin
                op_ren = 1'b1;
            end
        end

        if (start_go_c) begin
            pass_nxt       = 1'b0;
            fail_count_nxt = '0;
            fail_addr_nxt  = '0;
            fail_elem_nxt  = '0;
            fail_data_nxt  = '0;
        end else if (mismatch_c) begin
            if (fail_count != '1) begin
                fail_count_nxt = fail_count + CNT_W'(1);
            end
            if (fail_count == '0) begin
                fail_addr_nxt = cmp_addr;
                fail_elem_nxt = cmp_elem;
                fail_data_nxt = mem_dout;
            end
        end

        if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
            pass_nxt = (fail_count_nxt == '0);
        end
    end

    // Registered outputs and read-compare pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
            mem_din    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
            fail_count <= '0;
            cmp_vld    <= 1'b0;
            cmp_exp    <= '0;
            cmp_addr   <= '0;
            cmp_elem   <= '0;
        end else begin
            mem_wen    <= op_wen;
            mem_ren    <= op_ren;
            mem_din    <= op_din;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            fail_addr  <= fail_addr_nxt;
            fail_elem  <= fail_elem_nxt;
            fail_data  <= fail_data_nxt;
            fail_count <= fail_count_nxt;
            cmp_vld    <= mem_ren;
            cmp_exp    <= {DATA{cur_cfg.rd_bg}};
            cmp_addr   <= mem_addr;
            cmp_elem   <= elem;
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural memory with injectable stuck-at bit,
// op-sequence scoreboard and per-run result scoreboard.
module tb_mbist_march_ctrl;

    localparam int unsigned ADDR = 4;
    localparam int unsigned DATA = 8;
    localparam int unsigned N    = 16;

`ifdef MBIST_STOP_ON_FAIL_EN
    localparam int FAULT_OPS  = 28;
    localparam int FAULT_DONE = 29;
    localparam int FAULT_CNT  = 1;
    localparam int FAULT_NW   = 22;
    localparam int FAULT_NR   = 6;
`else
    localparam int FAULT_OPS  = 160;
    localparam int FAULT_DONE = 162;
    localparam int FAULT_CNT  = 3;
    localparam int FAULT_NW   = 80;
    localparam int FAULT_NR   = 80;
`endif

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            mem_wen, mem_ren;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_din, mem_dout;
    logic            busy, done, pass;
    logic [ADDR-1:0] fail_addr;
    logic [2:0]      fail_elem;
    logic [DATA-1:0] fail_data;
    logic [7:0]      fail_count;

    mbist_march_ctrl #(.ADDR(ADDR), .DATA(DATA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_data  (fail_data),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with registered read data and optional bit0 stuck-at-1 at address 5
    logic [DATA-1:0] mem [N];
    bit              fault_en;
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_addr] | ((fault_en && mem_addr == 4'd5) ? 8'h01 : 8'h00);
    end

    typedef struct packed {
        logic            w;
        logic [ADDR-1:0] a;
        logic [DATA-1:0] d;
    } op_t;

    typedef struct {
        int              done_cyc;
        logic            pass;
        logic [7:0]      cnt;
        logic [ADDR-1:0] faddr;
        logic [2:0]      felem;
        logic [DATA-1:0] fdata;
    } res_t;

    op_t  ops_q[$];
    res_t res_q[$];
    int   tests = 0;
    int   fails = 0;
    int   nw = 0;
    int   nr = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk_res(int c, logic p, logic [7:0] n, logic [3:0] a, logic [2:0] e, logic [7:0] d);
        res_t r;
        r.done_cyc = c; r.pass = p; r.cnt = n; r.faddr = a; r.felem = e; r.fdata = d;
        return r;
    endfunction

    // Expected March C- op stream; only the first 'limit' ops are queued
    function automatic void push_march(int limit);
        op_t seq[$];
        for (int a = 0; a < 16; a++) seq.push_back('{1'b1, 4'(a), 8'h00});
        for (int a = 0; a < 16; a++) begin
            seq.push_back('{1'b0, 4'(a), 8'h00}); seq.push_back('{1'b1, 4'(a), 8'hFF});
        end
        for (int a = 0; a < 16; a++) begin
            seq.push_back('{1'b0, 4'(a), 8'h00}); seq.push_back('{1'b1, 4'(a), 8'h00});
        end
        for (int a = 15; a >= 0; a--) begin
            seq.push_back('{1'b0, 4'(a), 8'h00}); seq.push_back('{1'b1, 4'(a), 8'hFF});
        end
        for (int a = 15; a >= 0; a--) begin
            seq.push_back('{1'b0, 4'(a), 8'h00}); seq.push_back('{1'b1, 4'(a), 8'h00});
        end
        for (int a = 0; a < 16; a++) seq.push_back('{1'b0, 4'(a), 8'h00});
        for (int i = 0; i < limit; i++) ops_q.push_back(seq[i]);
    endfunction

    // Op monitor: every memory op must be the next one of the expected stream
    always @(negedge clk) begin
        op_t e;
        if (rst_n && (mem_wen || mem_ren)) begin
            if (mem_wen) nw++;
            else         nr++;
            chk("wen_ren_exclusive", 32'(mem_wen & mem_ren), 32'd0);
            chk("op_expected", 32'(ops_q.size() != 0), 32'd1);
            if (ops_q.size() != 0) begin
                e = ops_q.pop_front();
                chk("op_kind", 32'(mem_wen), 32'(e.w));
                chk("op_addr", 32'(mem_addr), 32'(e.a));
                if (e.w) chk("op_din", 32'(mem_din), 32'(e.d));
            end
        end
    end

    task automatic start_run(int nops, bit push_res, res_t r, bit hold);
        start = 1'b1;
        push_march(nops);
        if (push_res) res_q.push_back(r);
        nw = 0;
        nr = 0;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Wait for done counting cycles after the start edge; cyc = -1 on timeout
    task automatic run_wait(int k0, output int cyc, output bit busy_ok);
        cyc = -1;
        busy_ok = 1'b1;
        for (int k = k0; k <= 400; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                return;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic check_result(int cyc, bit busy_ok);
        res_t e;
        e = res_q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("busy_window", 32'(busy_ok), 32'd1);
        chk("pass", 32'(pass), 32'(e.pass));
        chk("fail_count", 32'(fail_count), 32'(e.cnt));
        chk("fail_addr", 32'(fail_addr), 32'(e.faddr));
        chk("fail_elem", 32'(fail_elem), 32'(e.felem));
        chk("fail_data", 32'(fail_data), 32'(e.fdata));
        chk("ops_consumed", ops_q.size(), 0);
    endtask

    initial begin
        int cyc;
        bit bok;
        rst_n = 1'b0;
        start = 1'b0;
        fault_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({mem_wen, mem_ren, busy, done, pass, mem_addr, mem_din}), 32'd0);
        chk("rst_result", 32'({fail_addr, fail_elem, fail_data, fail_count}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_quiet", 32'({mem_wen, mem_ren, busy, done}), 32'd0);

        // Fault-free run
        start_run(160, 1'b1, mk_res(162, 1'b1, 8'd0, 4'd0, 3'd0, 8'h00), 1'b0);
        run_wait(1, cyc, bok);
        check_result(cyc, bok);
        chk("writes", nw, 80);
        chk("reads", nr, 80);
        repeat (3) @(negedge clk);
        chk("done_held", 32'({done, busy, mem_wen, mem_ren, pass}), 32'b10001);

        // Stuck-at-1 on bit 0 of address 5
        fault_en = 1'b1;
        start_run(FAULT_OPS, 1'b1, mk_res(FAULT_DONE, 1'b0, 8'(FAULT_CNT), 4'd5, 3'd1, 8'h01), 1'b0);
        run_wait(1, cyc, bok);
        check_result(cyc, bok);
        chk("fault_writes", nw, FAULT_NW);
        chk("fault_reads", nr, FAULT_NR);
        repeat (4) @(negedge clk);
        chk("fault_done_held", 32'({done, pass, mem_wen, mem_ren}), 32'b1000);
        fault_en = 1'b0;

        // Reset asserted in cycle 50 of a run
        start_run(160, 1'b0, mk_res(0, 1'b0, 8'd0, 4'd0, 3'd0, 8'h00), 1'b0);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 32'({mem_wen, mem_ren, busy, done, pass, mem_addr, mem_din}), 32'd0);
        chk("abort_result", 32'({fail_addr, fail_elem, fail_data, fail_count}), 32'd0);
        ops_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'({mem_wen, mem_ren, busy, done}), 32'd0);
        start_run(160, 1'b1, mk_res(162, 1'b1, 8'd0, 4'd0, 3'd0, 8'h00), 1'b0);
        run_wait(1, cyc, bok);
        check_result(cyc, bok);

        // Start held high: faulty run, then restart from DONE with results cleared
        fault_en = 1'b1;
        start_run(FAULT_OPS, 1'b1, mk_res(FAULT_DONE, 1'b0, 8'(FAULT_CNT), 4'd5, 3'd1, 8'h01), 1'b1);
        run_wait(1, cyc, bok);
        check_result(cyc, bok);
        push_march(160);
        res_q.push_back(mk_res(162, 1'b1, 8'd0, 4'd0, 3'd0, 8'h00));
        fault_en = 1'b0;
        @(negedge clk);
        chk("restart_busy", 32'({busy, done}), 32'b10);
        chk("restart_cleared", 32'({pass, fail_addr, fail_elem, fail_data, fail_count}), 32'd0);
        start = 1'b0;
        run_wait(2, cyc, bok);
        check_result(cyc, bok);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

MBIST engine that drives the memory under test as its sole initiator. It runs a March C- algorithm over the full address space using the memory's `wen`/`ren`/`address`/`din` port and checks the registered `dout` read data. It reports pass/fail, the first failing location and a saturating error count. It sits between the SoC test-mode logic and the memory macro.

## Interface
- `ADDR`, 4, memory address width; N = 2^ADDR words
- `DATA`, 8, memory data width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level; sampled only in IDLE or DONE
- `mem_wen`  out  1  write enable to memory
- `mem_ren`  out  1  read enable to memory
- `mem_addr`  out  ADDR  memory address
- `mem_din`  out  DATA  write data
- `mem_dout`  in  DATA  memory read data, valid the cycle after `mem_ren`
- `busy`  out  1  test in progress
- `done`  out  1  test finished; held until next start or reset
- `pass`  out  1  valid when `done`; 1 = no mismatch
- `fail_addr`  out  ADDR  address of first mismatch
- `fail_elem`  out  3  March element index (0–5) of first mismatch
- `fail_data`  out  DATA  actual data read at first mismatch
- `fail_count`  out  8  mismatch count, saturates at 255

## Operation
- Background patterns: 0 = all zeros, 1 = all ones.
- Elements:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇕(r0), executed ascending
- ⇑ runs address 0→N-1. ⇓ runs N-1→0.
- FSM states and transitions:
  - IDLE: on `start`, go to RUN.
  - RUN: element counter, R/W phase bit and address counter. After the last op of M5, go to DRAIN.
  - DRAIN: one cycle, go to DONE.
  - DONE: on `start`, go to RUN.
- Entering RUN clears `pass`, `fail_*` and `fail_count`.
- One operation per cycle. `mem_wen` and `mem_ren` are never both 1. Both are 0 in IDLE, DRAIN and DONE.
- Compare: a read issued in cycle t is compared against the expected background in cycle t+1. In that cycle the next op (a write, or the next M5 read) is already being driven.
- On mismatch:
  - `fail_count` increments, saturating at 255.
  - The first mismatch latches `fail_addr`, `fail_elem` and `fail_data`. Later mismatches do not update them.
- At DONE, `pass` = (`fail_count` == 0).
- `start` during RUN or DRAIN is ignored.

## Timing
- All outputs are registered.
- Reset values: every output 0, FSM in IDLE.
- `rst_n` asserted mid-run aborts immediately. After release, the block waits in IDLE.
- Start is sampled at edge E0.
- Ops occupy cycles 1..10N after E0:
  - M0: cycles 1..N
  - M1–M4: 2N cycles each
  - M5: N cycles
- The final compare happens in cycle 10N+1. `done` is high from cycle 10N+2 (162 for ADDR=4).
- Totals per run: 5N writes and 5N reads.
- `busy` is high from cycle 1 through 10N+1.

## Configuration
- `MBIST_STOP_ON_FAIL_EN` defined:
  - A mismatch detected in compare cycle c ends the test.
  - No op is issued from cycle c+1.
  - `done` = 1 and `pass` = 0 from cycle c+1.
  - `fail_count` = 1.
- Not defined: the test always runs to completion and counts every mismatch.

## Structure
- Shared package `mbist_pkg`:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - element index constants M0..M5
  - per-element tables: direction, first-read background, write background, read-only flag
- Sub-module `mbist_addr_gen`:
  - up/down address counter with load and terminal-count flag
  - load value 0 for ascending, N-1 for descending

## Test plan
- Fault-free memory, ADDR=4/DATA=8, start pulse → `done` first high at cycle 162, `pass`=1, `fail_count`=0, 80 writes and 80 reads observed.
- Bit 0 of address 5 stuck-at-1 → `pass`=0, `fail_addr`=5, `fail_elem`=1, `fail_data`=0x01, `fail_count`=3 (failing reads in M1, M3, M5).
- Address monitor → M0–M2 and M5 ascend 0..15; M3 and M4 descend 15..0. Every M1–M4 read is followed by a write to the same address.
- `rst_n` pulsed low at cycle 50 → all outputs 0 immediately. A fresh start after release completes with `pass`=1 at 162 cycles.
- `start` held high throughout → sequence unchanged during RUN. The block restarts from DONE and the results are cleared on re-entry to RUN.
- `MBIST_STOP_ON_FAIL_EN`, stuck-at fault as above → mismatch compared in cycle 28, no memory ops from cycle 29. `done`=1 and `pass`=0 at cycle 29, `fail_count`=1.
